lsu_ctrl: RTL and testbench

Load/store unit that sits after the ALU in the RV32I datapath. It takes the ALU-computed effective address plus store data and funct3, and runs one memory transaction per request over a req/ack data-memory port with variable wait states. It handles byte-lane steering, byte masks, load sign/zero extension, misalignment and illegal-width detection, and a bus timeout. The core stalls on `o_lsu_ready`/`o_lsu_done`.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 54 +++++
 rtl/lsu_ctrl.sv | 121 ++++++++++++
 tb/tb_lsu_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the RV32I load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_e;

  function automatic logic is_illegal(input logic wren, input logic [2:0] funct3);
    if (wren) return !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  // funct3[1:0] encodes the access size for every legal load/store.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == 2'b01) && offset[0]) || ((size == 2'b10) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extract plus sign/zero extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        wren,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  bmask,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    bmask = 4'b1111;
    wdata = 32'd0;
    if (wren) begin
      case (funct3)
        F3_SB: begin
          bmask = 4'b0001 << offset;
          wdata = {4{st_data[7:0]}};
        end
        F3_SH: begin
          bmask = 4'b0011 << offset;
          wdata = {2{st_data[15:0]}};
        end
        default: begin
          bmask = 4'b1111;
          wdata = st_data;
        end
      endcase
    end
  end

  always_comb begin
    ld_data = 32'd0;
    case (funct3)
      F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   ld_data = rdata;
      F3_LBU:  ld_data = {24'd0, byte_sel};
      F3_LHU:  ld_data = {16'd0, half_sel};
      default: ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: request capture, error checks, req/ack memory FSM with timeout.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  output logic        o_lsu_ready,
  output logic        o_lsu_done,
  output logic [31:0] o_ld_data,
  output logic [1:0]  o_lsu_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a request transfers on a rising edge where i_lsu_valid && o_lsu_ready;
  // the memory side transfers on an edge where o_mem_req && i_mem_ack, and o_mem_req
  // with its address/data/mask stays stable until that edge or the timeout.

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  lsu_state_e  state;
  logic        wren_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] st_q;
  logic [7:0]  cnt;
  logic [31:0] ld_q;
  logic [1:0]  err_q;

  logic [3:0]  bmask;
  logic [31:0] wdata;
  logic [31:0] ld_ext;

  lsu_align u_align (
    .funct3  (f3_q),
    .offset  (addr_q[1:0]),
    .wren    (wren_q),
    .st_data (st_q),
    .rdata   (i_mem_rdata),
    .bmask   (bmask),
    .wdata   (wdata),
    .ld_data (ld_ext)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      wren_q <= 1'b0;
      f3_q   <= 3'd0;
      addr_q <= 32'd0;
      st_q   <= 32'd0;
      cnt    <= 8'd0;
      ld_q   <= 32'd0;
      err_q  <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (i_lsu_valid) begin
            wren_q <= i_lsu_wren;
            f3_q   <= i_lsu_funct3;
            addr_q <= i_lsu_addr;
            st_q   <= i_st_data;
            cnt    <= 8'd0;
            ld_q   <= 32'd0;
            // Illegal width is checked before alignment since size is meaningless then.
            if (is_illegal(i_lsu_wren, i_lsu_funct3)) begin
              err_q <= ERR_ILLEGAL;
              state <= DONE;
            end else if (is_misaligned(i_lsu_funct3[1:0], i_lsu_addr[1:0])) begin
              err_q <= ERR_MISALIGN;
              state <= DONE;
            end else begin
              err_q <= ERR_NONE;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            ld_q  <= wren_q ? 32'd0 : ld_ext;
            err_q <= ERR_NONE;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            ld_q  <= 32'd0;
            err_q <= ERR_TIMEOUT;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_lsu_ready = (state == IDLE);
  assign o_lsu_done  = (state == DONE);
  assign o_ld_data   = o_lsu_done ? ld_q : 32'd0;
  assign o_lsu_err   = o_lsu_done ? err_q : 2'b00;
  assign o_mem_req   = (state == REQ);
  assign o_mem_we    = o_mem_req & wren_q;
  assign o_mem_addr  = o_mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign o_mem_bmask = o_mem_req ? bmask : 4'd0;
  assign o_mem_wdata = o_mem_req ? wdata : 32'd0;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, random traffic, reset-abort sequence.
module tb_lsu_ctrl;

  localparam int MT = 4;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_wren;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] st_data;
  logic        lsu_ready;
  logic        lsu_done;
  logic [31:0] ld_data;
  logic [1:0]  lsu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_bmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  lsu_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_lsu_valid  (lsu_valid),
    .i_lsu_wren   (lsu_wren),
    .i_lsu_funct3 (lsu_funct3),
    .i_lsu_addr   (lsu_addr),
    .i_st_data    (st_data),
    .o_lsu_ready  (lsu_ready),
    .o_lsu_done   (lsu_done),
    .o_ld_data    (ld_data),
    .o_lsu_err    (lsu_err),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_bmask  (mem_bmask),
    .o_mem_wdata  (mem_wdata),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] rdata;
    int          ack_wait;
    logic [1:0]  e_err;
    logic [31:0] e_data;
    logic [3:0]  e_bmask;
    logic [31:0] e_wdata;
    int          e_req;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: computes results straight from the load/store rules with arithmetic.
  task automatic model(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] st, input logic [31:0] rdata, input int ack_wait,
                       output logic [1:0] e_err, output logic [31:0] e_data,
                       output logic [3:0] e_bmask, output logic [31:0] e_wdata, output int e_req);
    int off;
    int unsigned b, h, ld;
    bit illegal, misal, ack_ok;
    off     = int'(addr % 4);
    illegal = wren ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    misal   = (f3[1:0] == 2'd1 && (addr % 2) != 0) || (f3[1:0] == 2'd2 && off != 0);
    ack_ok  = (ack_wait >= 1) && (ack_wait <= MT);
    b  = (rdata >> (8 * off)) & 32'hFF;
    h  = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    ld = (b >= 128) ? b - 256 : b;
      3'd1:    ld = (h >= 32768) ? h - 65536 : h;
      3'd2:    ld = rdata;
      3'd4:    ld = b;
      3'd5:    ld = h;
      default: ld = 0;
    endcase
    if (!wren) e_bmask = 4'hF;
    else if (f3 == 3'd0) e_bmask = 4'(1 << off);
    else if (f3 == 3'd1) e_bmask = 4'(3 << off);
    else e_bmask = 4'hF;
    if (f3 == 3'd0) e_wdata = (st & 32'hFF) * 32'h0101_0101;
    else if (f3 == 3'd1) e_wdata = (st & 32'hFFFF) * 32'h0001_0001;
    else e_wdata = st;
    if (illegal) e_err = 2'd2;
    else if (misal) e_err = 2'd1;
    else if (ack_ok) e_err = 2'd0;
    else e_err = 2'd3;
    e_req  = (e_err == 2'd1 || e_err == 2'd2) ? 0 : (ack_ok ? ack_wait : MT);
    e_data = (e_err == 2'd0 && !wren) ? ld : 32'd0;
  endtask

  // driver: called at a negedge with the unit idle; returns at the negedge after done
  task automatic run_txn(input string tag, input vec_t v);
    int  reqs;
    int  done_at;
    bit  seen_done;
    logic [31:0] exp_d;
    reqs = 0;
    done_at = 0;
    seen_done = 0;
    chk({tag, " ready"}, {31'd0, lsu_ready}, 32'd1);
    lsu_valid  = 1'b1;
    lsu_wren   = v.wren;
    lsu_funct3 = v.f3;
    lsu_addr   = v.addr;
    st_data    = v.st;
    exp_q.push_back(v.e_data);
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0;
    lsu_addr  = $urandom;
    st_data   = $urandom;
    lsu_funct3 = 3'($urandom_range(0, 7));
    for (int k = 1; k <= MT + 6; k++) begin
      if (lsu_done) begin
        seen_done = 1;
        done_at = k;
        break;
      end
      if (mem_req) begin
        reqs++;
        if (reqs == 1) begin
          chk({tag, " addr"}, mem_addr, {v.addr[31:2], 2'b00});
          chk({tag, " we"}, {31'd0, mem_we}, {31'd0, v.wren});
          chk({tag, " bmask"}, {28'd0, mem_bmask}, {28'd0, v.e_bmask});
          if (v.wren) chk({tag, " wdata"}, mem_wdata, v.e_wdata);
        end
        mem_ack   = (reqs == v.ack_wait);
        mem_rdata = mem_ack ? v.rdata : $urandom;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(negedge clk);
    end
    exp_d = exp_q.pop_front();
    if (!seen_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s done: no done pulse within %0d cycles", tag, MT + 6);
    end else begin
      chk({tag, " err"}, {30'd0, lsu_err}, {30'd0, v.e_err});
      chk({tag, " ready_in_done"}, {31'd0, lsu_ready}, 32'd0);
      if (!v.wren) chk({tag, " ld_data"}, ld_data, exp_d);
      chk({tag, " done_cycle"}, done_at, v.e_req + 1);
    end
    chk({tag, " req_cycles"}, reqs, v.e_req);
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1;
    lsu_valid = 1'b0;
    lsu_wren = 1'b0;
    lsu_funct3 = 3'd0;
    lsu_addr = 32'd0;
    st_data = 32'd0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst done", {31'd0, lsu_done}, 32'd0);
    chk("rst req", {31'd0, mem_req}, 32'd0);
    chk("rst ld_data", ld_data, 32'd0);
    chk("rst err", {30'd0, lsu_err}, 32'd0);
    chk("rst state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //          wren f3    addr         st            rdata         ack err  data          bm     wdata         req
    vecs.push_back('{1'b0, 3'd0, 32'h103, 32'h0,        32'h80AB_CD12, 3, 2'd0, 32'hFFFF_FF80, 4'hF, 32'h0,         3});
    vecs.push_back('{1'b0, 3'd5, 32'h202, 32'h0,        32'h8001_1234, 1, 2'd0, 32'h0000_8001, 4'hF, 32'h0,         1});
    vecs.push_back('{1'b1, 3'd0, 32'h301, 32'hDEAD_BE5A, 32'h0,        2, 2'd0, 32'h0,         4'h2, 32'h5A5A_5A5A, 2});
    vecs.push_back('{1'b1, 3'd1, 32'h302, 32'h1234_ABCD, 32'h0,        1, 2'd0, 32'h0,         4'hC, 32'hABCD_ABCD, 1});
    vecs.push_back('{1'b0, 3'd2, 32'h105, 32'h0,        32'h0,         1, 2'd1, 32'h0,         4'hF, 32'h0,         0});
    vecs.push_back('{1'b0, 3'd6, 32'h100, 32'h0,        32'h0,         1, 2'd2, 32'h0,         4'hF, 32'h0,         0});
    vecs.push_back('{1'b0, 3'd2, 32'h108, 32'h0,        32'h5555_5555, 0, 2'd3, 32'h0,         4'hF, 32'h0,         4});
    vecs.push_back('{1'b0, 3'd2, 32'h10C, 32'h0,        32'h1122_3344, 4, 2'd0, 32'h1122_3344, 4'hF, 32'h0,         4});
    vecs.push_back('{1'b1, 3'd2, 32'h010, 32'hCAFE_F00D, 32'h0,        1, 2'd0, 32'h0,         4'hF, 32'hCAFE_F00D, 1});
    vecs.push_back('{1'b1, 3'd3, 32'h010, 32'h0,        32'h0,         1, 2'd2, 32'h0,         4'hF, 32'h0,         0});
    vecs.push_back('{1'b1, 3'd1, 32'h101, 32'h0,        32'h0,         1, 2'd1, 32'h0,         4'hF, 32'h0,         0});
    vecs.push_back('{1'b0, 3'd7, 32'h003, 32'h0,        32'h0,         1, 2'd2, 32'h0,         4'hF, 32'h0,         0});
    vecs.push_back('{1'b0, 3'd1, 32'h000, 32'h0,        32'h0000_8000, 2, 2'd0, 32'hFFFF_8000, 4'hF, 32'h0,         2});
    vecs.push_back('{1'b0, 3'd4, 32'h003, 32'h0,        32'hF100_0000, 1, 2'd0, 32'h0000_00F1, 4'hF, 32'h0,         1});
    vecs.push_back('{1'b1, 3'd0, 32'h003, 32'h0000_00A5, 32'h0,        5, 2'd3, 32'h0,         4'h8, 32'hA5A5_A5A5, 4});

    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 60; i++) begin
      rv.wren     = 1'($urandom_range(0, 1));
      rv.f3       = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                    : (rv.wren ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      rv.addr     = $urandom;
      rv.st       = $urandom;
      rv.rdata    = $urandom;
      rv.ack_wait = $urandom_range(0, MT + 1);
      model(rv.wren, rv.f3, rv.addr, rv.st, rv.rdata, rv.ack_wait,
            rv.e_err, rv.e_data, rv.e_bmask, rv.e_wdata, rv.e_req);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    // reset while a request is outstanding
    lsu_valid = 1'b1;
    lsu_wren = 1'b0;
    lsu_funct3 = 3'd2;
    lsu_addr = 32'h400;
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0;
    chk("mid_rst req_before", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    chk("mid_rst req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst done", {31'd0, lsu_done}, 32'd0);
    chk("mid_rst ready", {31'd0, lsu_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst no_done", {31'd0, lsu_done}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
